// File: rtl/microtile_edge_counter.sv
// Rising-edge counter tile: synchronised channel inputs, per-channel counters, byte-wide readout mux.
// Optional MICROTILE_EDGE_CNT_SAT_EN makes counters saturate instead of wrapping.
module microtile_edge_counter #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  // Top bit of each sync word carries the clear request alongside the channels.
  logic [CHANNELS:0]   sync_r [SYNC_STAGES];
  logic [CHANNELS:0]   raw_s;
  logic [CHANNELS:0]   synced_s;
  logic [CHANNELS-1:0] ch_s;
  logic                clr_s;
  logic [CHANNELS-1:0] prev_r;
  logic [CHANNELS-1:0] rise_s;
  logic [WIDTH-1:0]    cnt_r [CHANNELS];
  logic [1:0]          sel_s;
  logic [15:0]         sel_cnt_s;

  assign raw_s    = {ui_in[7], ui_in[CHANNELS-1:0]};
  assign synced_s = sync_r[SYNC_STAGES-1];
  assign ch_s     = synced_s[CHANNELS-1:0];
  assign clr_s    = synced_s[CHANNELS];
  assign rise_s   = ch_s & ~prev_r;
  assign sel_s    = ui_in[5:4];

  // Synchroniser chains and previous-value registers for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= ch_s;
    end
  end

  // Per-channel counters; clear dominates and rises are dropped while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (clr_s) begin
          cnt_r[k] <= '0;
        end else if (ena && rise_s[k]) begin
`ifdef MICROTILE_EDGE_CNT_SAT_EN
          if (cnt_r[k] != {WIDTH{1'b1}}) begin
            cnt_r[k] <= cnt_r[k] + WIDTH'(1);
          end else begin
            cnt_r[k] <= cnt_r[k];
          end
`else
          cnt_r[k] <= cnt_r[k] + WIDTH'(1);
`endif
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  // Readout mux: unselectable channels and bits above WIDTH read as zero.
  always_comb begin
    sel_cnt_s = 16'h0000;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_cnt_s = sel_cnt_s | ((sel_s == 2'(k)) ? 16'(cnt_r[k]) : 16'h0000);
    end
    if (ui_in[6]) begin
      uo_out = sel_cnt_s[15:8];
    end else begin
      uo_out = sel_cnt_s[7:0];
    end
  end

endmodule

// File: tb/tb_microtile_edge_counter.sv
// Bench for microtile_edge_counter: default instance plus a 3-channel, 12-bit, 3-stage instance,
// both checked every cycle against an input-history reference model.
module tb_microtile_edge_counter;

  localparam int SS_MAIN = 2;
  localparam int SS_W12  = 3;
`ifdef MICROTILE_EDGE_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_main;
  logic [7:0] uo_w12;

  int n_vec;
  int n_err;

  logic [7:0] hist[$];
  int mc[4];
  int mw[3];

  typedef struct {
    logic [7:0] ui;
    logic [7:0] exp_main;
    logic [7:0] exp_w12;
  } vec_t;
  vec_t tbl[16];

  microtile_edge_counter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_main)
  );

  microtile_edge_counter #(.CHANNELS(3), .WIDTH(12), .SYNC_STAGES(3)) dut_w12 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_w12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] hv(int idx);
    if (idx >= 0 && idx < hist.size()) return hist[idx];
    return 8'h00;
  endfunction

  function automatic int nxt(int c, bit rise, bit clr, bit en, int w);
    int mx;
    mx = (1 << w) - 1;
    if (clr) return 0;
    if (en && rise) begin
      if (SAT && c == mx) return c;
      return (c + 1) & mx;
    end
    return c;
  endfunction

  function automatic logic [7:0] expv(int cval, logic bs);
    return bs ? 8'((cval >> 8) & 255) : 8'(cval & 255);
  endfunction

  task automatic model_reset();
    hist.delete();
    foreach (mc[k]) mc[k] = 0;
    foreach (mw[k]) mw[k] = 0;
  endtask

  // A channel counts at the edge where its value seen SS samples ago is 1 and SS+1 samples ago is 0.
  task automatic model_edge();
    int t;
    logic [7:0] s2, p2, s3, p3;
    hist.push_back(ui_in);
    t  = hist.size() - 1;
    s2 = hv(t - SS_MAIN);
    p2 = hv(t - SS_MAIN - 1);
    s3 = hv(t - SS_W12);
    p3 = hv(t - SS_W12 - 1);
    for (int k = 0; k < 4; k++) mc[k] = nxt(mc[k], s2[k] & ~p2[k], s2[7], ena, 8);
    for (int k = 0; k < 3; k++) mw[k] = nxt(mw[k], s3[k] & ~p3[k], s3[7], ena, 12);
  endtask

  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_model();
    int sel;
    sel = int'(ui_in[5:4]);
    cmp("model_main", uo_main, expv(mc[sel], ui_in[6]));
    cmp("model_w12", uo_w12, expv((sel < 3) ? mw[sel] : 0, ui_in[6]));
  endtask

  task automatic step(input logic [7:0] ui, input logic en);
    @(negedge clk);
    ui_in = ui;
    ena   = en;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic pulse(input logic [7:0] mask, input int n);
    repeat (n) begin
      step(mask, 1'b1);
      step(8'h00, 1'b1);
    end
  endtask

  task automatic settle();
    repeat (5) step(8'h00, 1'b1);
  endtask

  task automatic do_clear();
    repeat (5) step(8'h80, 1'b1);
    settle();
  endtask

  task automatic peek(string name, input logic [1:0] sel, input logic bs,
                      input logic [7:0] em, input logic [7:0] e12);
    ui_in = {1'b0, bs, sel, 4'h0};
    #1;
    cmp({name, "_main"}, uo_main, em);
    cmp({name, "_w12"}, uo_w12, e12);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();

    tbl[0]  = '{8'h01, 8'h00, 8'h00};
    tbl[1]  = '{8'h00, 8'h00, 8'h00};
    tbl[2]  = '{8'h00, 8'h01, 8'h00};
    tbl[3]  = '{8'h00, 8'h01, 8'h01};
    tbl[4]  = '{8'h01, 8'h01, 8'h01};
    tbl[5]  = '{8'h01, 8'h01, 8'h01};
    tbl[6]  = '{8'h01, 8'h02, 8'h01};
    for (int i = 7; i < 14; i++) tbl[i] = '{8'h01, 8'h02, 8'h02};
    tbl[14] = '{8'h00, 8'h02, 8'h02};
    tbl[15] = '{8'h00, 8'h02, 8'h02};

    // Reset and idle
    rst_n = 1'b0;
    ena   = 1'b1;
    ui_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    peek("reset", 2'd0, 1'b0, 8'h00, 8'h00);
    repeat (20) step(8'h00, 1'b1);
    peek("idle", 2'd0, 1'b0, 8'h00, 8'h00);

    // Latency and long-pulse table
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].ui, 1'b1);
      cmp($sformatf("tbl%0d_main", i), uo_main, tbl[i].exp_main);
      cmp($sformatf("tbl%0d_w12", i), uo_w12, tbl[i].exp_w12);
    end

    // Multi-channel with simultaneous ch0+ch1 pulses
    do_clear();
    pulse(8'h03, 3);
    pulse(8'h02, 2);
    pulse(8'h04, 7);
    pulse(8'h08, 2);
    settle();
    peek("sel0", 2'd0, 1'b0, 8'h03, 8'h03);
    peek("sel1", 2'd1, 1'b0, 8'h05, 8'h05);
    peek("sel2", 2'd2, 1'b0, 8'h07, 8'h07);
    peek("sel3", 2'd3, 1'b0, 8'h02, 8'h00);
    peek("sel2_hi", 2'd2, 1'b1, 8'h00, 8'h00);

    // Wrap / saturation and 12-bit byte select
    do_clear();
    pulse(8'h02, 260);
    settle();
    peek("wrap_lo", 2'd1, 1'b0, SAT ? 8'hFF : 8'h04, 8'h04);
    peek("wrap_hi", 2'd1, 1'b1, 8'h00, 8'h01);
    pulse(8'h04, 300);
    settle();
    peek("w300_lo", 2'd2, 1'b0, SAT ? 8'hFF : 8'h2C, 8'h2C);
    peek("w300_hi", 2'd2, 1'b1, 8'h00, 8'h01);

    // Clear while pulsing, then ena gating
    do_clear();
    pulse(8'h01, 9);
    settle();
    peek("pre_clear", 2'd0, 1'b0, 8'h09, 8'h09);
    step(8'h81, 1'b1);
    step(8'h80, 1'b1);
    step(8'h81, 1'b1);
    step(8'h80, 1'b1);
    settle();
    peek("cleared", 2'd0, 1'b0, 8'h00, 8'h00);
    repeat (5) begin
      step(8'h01, 1'b0);
      step(8'h00, 1'b0);
    end
    repeat (5) step(8'h00, 1'b0);
    peek("ena_low", 2'd0, 1'b0, 8'h00, 8'h00);
    pulse(8'h01, 1);
    settle();
    peek("ena_high", 2'd0, 1'b0, 8'h01, 8'h01);

    // Randomised traffic against the model
    repeat (400) begin
      logic [7:0] r;
      r = 8'($urandom);
      r[7] = ($urandom_range(0, 15) == 0);
      step(r, ($urandom_range(0, 3) != 0));
    end

    // Reset mid-count with a pulse in flight
    do_clear();
    pulse(8'h01, 3);
    settle();
    peek("pre_rst", 2'd0, 1'b0, 8'h03, 8'h03);
    step(8'h01, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_main", uo_main, 8'h00);
    cmp("async_rst_w12", uo_w12, 8'h00);
    model_reset();
    @(negedge clk);
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step(8'h00, 1'b1);
    peek("post_rst", 2'd0, 1'b0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
